// File: rtl/cla_pkg.sv
// Shared definitions for the byte-serial carry-lookahead adder.
package cla_pkg;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/cla_behavioral.sv
// 8-bit carry-lookahead slice: every carry is a flat generate/propagate product term.
module cla_behavioral
  import cla_pkg::*;
(
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;
  logic              acc;
  logic              prod;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        acc  = acc | (prod & g[i-1-k]);
        prod = prod & p[i-1-k];
      end
      c[i+1] = acc | (prod & cin);
    end
  end

  assign sum  = p ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Byte-serial add/subtract: one shared CLA slice processes a byte per RUN cycle.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*NBYTES-1:0]     a,
  input  logic [8*NBYTES-1:0]     b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NBYTES-1:0]     sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int unsigned W = 8 * NBYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BYTE_W-1:0] slice_a;
  logic [BYTE_W-1:0] slice_b;
  logic [BYTE_W-1:0] slice_sum;
  logic              slice_cout;

  assign slice_a = a_q[idx_q*BYTE_W +: BYTE_W];
  assign slice_b = b_q[idx_q*BYTE_W +: BYTE_W];

  cla_behavioral u_slice (
    .sum  (slice_sum),
    .cout (slice_cout),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*BYTE_W +: BYTE_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          // Overflow: operand signs agree but the result sign differs.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[BYTE_W-1] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder with NBYTES=4: driver queues expectations, monitor checks results.
module tb_cla_seq_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  cla_seq_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    string        nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   t_first;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts, input logic [W-1:0] es, input logic ec,
                      input logic eo, input string nm, input bit push);
    exp_t e;
    wait_idle();
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    accept_cyc = cyc;
    if (push) begin
      e.s = es; e.c = ec; e.o = eo; e.nm = nm;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every DONE cycle against the head of the queue, pops on handshake.
  initial begin
    bit prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov)
          chk("latency", 64'(cyc - accept_cyc), 64'(NB));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum);
          end else begin
            chk({exp_q[0].nm, "_sum"}, 64'(sum), 64'(exp_q[0].s));
            chk({exp_q[0].nm, "_cout_ovf"}, 64'({cout, ovf}), 64'({exp_q[0].c, exp_q[0].o}));
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'({sum, cout, ovf}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1", 1'b1);
    t_first = accept_cyc;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "carry_chain", 1'b1);
    chk("throughput", 64'(accept_cyc - t_first), 64'(NB + 2));
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf", 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow", 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf", 1'b1);
    send(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, "add_cin", 1'b1);

    // Stall in DONE with new operands presented on the input side.
    wait_idle();
    out_ready = 1'b0;
    send(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0, "stall", 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("stall_reached_done", 64'(out_valid), 64'd1);
    end
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'd1);

    // Reset while idx=2: the operation must vanish.
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, '0, 1'b0, 1'b0, "aborted", 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);

    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_rst", 1'b1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes, with W = 8*NBYTES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 sub  input  1  1 = compute a - b (a + ~b + 1); 0 = compute a + b + cin.
REQ-010 out_valid  output  1  sum, cout and ovf hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  result.
REQ-013 cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE, when in_valid=1: capture a, capture b_eff = sub ? ~b : b, set carry register = sub ? 1 : cin, set byte index = 0, clear the sum register, go to RUN.
REQ-018 RUN, each cycle: byte[idx] of a and b_eff plus the carry register pass through one 8-bit CLA slice; the slice sum writes sum byte idx; the slice carry-out loads the carry register.
REQ-019 RUN at idx = NBYTES-1: latch cout = slice carry-out, latch ovf = (a[W-1] == b_eff[W-1]) && (slice sum MSB != a[W-1]), go to DONE.
REQ-020 Otherwise in RUN, idx SHALL increment by 1; idx never wraps while in RUN.
REQ-021 Latency: the accept edge is cycle 0; out_valid SHALL rise NBYTES cycles later.
REQ-022 DONE: sum, cout and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 DONE with out_ready=1: go to IDLE on that edge; the result outputs keep their values until the next accept.
REQ-024 in_valid in RUN or DONE SHALL be ignored; the operands are not sampled.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 Sustained throughput SHALL be one operation per NBYTES+2 cycles when in_valid and out_ready are held high.
REQ-027 The a, b and cin inputs need not be held after the accept edge.

Reset
REQ-028 With rst=1 at a clock edge, the next state SHALL be IDLE, with sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, idx=0 and carry register=0.
REQ-029 rst SHALL take priority over every handshake; asserting it in RUN or DONE discards the operation in progress with no partial result visible.

Structure
REQ-030 Shared package cla_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the constant BYTE_W=8.
REQ-031 A single 8-bit carry-lookahead slice SHALL be instantiated as a sub-module (existing cell cla_behavioral: ports sum, cout, a, b, cin); it is reused every RUN cycle.
REQ-032 No combinational path SHALL exist from in_valid or out_ready to any output other than through registered state.

Verification (NBYTES=4)
REQ-033 a=0x000000FF, b=0x00000001, cin=0, sub=0 -> sum=0x00000100, cout=0, ovf=0; out_valid rises exactly 4 cycles after accept.
REQ-034 a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0; checks the carry chain across all bytes.
REQ-035 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-036 a=0x00000005, b=0x00000007, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; checks that cin is ignored for sub.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> sum, cout, ovf unchanged, in_ready=0; after out_ready=1, in_ready=1 on the next cycle.
REQ-038 Pulse rst for 1 cycle at idx=2 -> next cycle in_ready=1, out_valid=0, sum=0; a following 0x12345678 + 0x11111111 then yields sum=0x23456789.
